// File: rtl/hdmi_timing_pkg.sv
// Shared types and default 1024x600 timing for the HDMI timing controller.
package hdmi_timing_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } tctrl_state_t;

    // Field order matches the upstream word {blue, green, red}.
    typedef struct packed {
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } rgb_t;

    localparam int DEF_H_ACTIVE = 1024;
    localparam int DEF_H_FP     = 160;
    localparam int DEF_H_SYNC   = 20;
    localparam int DEF_H_BP     = 140;
    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FP     = 12;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 20;
    localparam bit DEF_SYNC_POL = 1'b0;

    // Colour of a vertical test bar: bit 2 drives blue, bit 1 green, bit 0 red.
    function automatic rgb_t bar_colour(input logic [2:0] bar);
        rgb_t c;
        c.b = bar[2] ? 8'hFF : 8'h00;
        c.g = bar[1] ? 8'hFF : 8'h00;
        c.r = bar[0] ? 8'hFF : 8'h00;
        return c;
    endfunction

endpackage

// File: rtl/hdmi_timing_ctrl_raster_counter.sv
// Raster position counters: hcnt runs across the line, vcnt advances at
// end of line; both are held at zero while the raster is not running.
module raster_counter #(
    parameter int H_TOTAL = 1344,
    parameter int V_TOTAL = 635,
    parameter int H_W     = $clog2(H_TOTAL),
    parameter int V_W     = $clog2(V_TOTAL)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           run,
    output logic [H_W-1:0] hcnt,
    output logic [V_W-1:0] vcnt,
    output logic           end_of_frame
);

    localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);

    logic end_of_line;

    assign end_of_line  = (hcnt == H_LAST);
    assign end_of_frame = end_of_line && (vcnt == V_LAST);

    // Advance position each pixel clock; wrap line and frame.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (end_of_line) begin
            hcnt <= '0;
            vcnt <= end_of_frame ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

endmodule

// File: rtl/hdmi_timing_ctrl.sv
// HDMI video timing scheduler: raster counters, sync/DE generation and the
// pixel pull from the upstream line store, with registered outputs to the
// TMDS encoders. Optional colour-bar generator under HDMI_TEST_PATTERN_EN.
module hdmi_timing_ctrl
    import hdmi_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = DEF_SYNC_POL
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        pix_valid,
    input  logic [23:0] pix_data,
`ifdef HDMI_TEST_PATTERN_EN
    input  logic        pattern_sel,
`endif
    output logic        pix_ready,
    output logic        frame_start,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        underflow,
    input  logic        underflow_clr,
    output logic [15:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    localparam int unsigned HA_U     = H_ACTIVE;
    localparam int unsigned VA_U     = V_ACTIVE;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

    tctrl_state_t   state_q;
    tctrl_state_t   state_d;
    logic           run;
    logic [H_W-1:0] hcnt;
    logic [V_W-1:0] vcnt;
    logic           end_of_frame;
    logic [31:0]    h_i;
    logic [31:0]    v_i;
    logic           active;
    logic           hs_act;
    logic           vs_act;
    logic           pat_on;
    rgb_t           bar_rgb;
    rgb_t           rgb_d;
    logic           uf_set;

    rgb_t           rgb_p1;
    logic           vld_p1;
    logic           hsync_p1;
    logic           vsync_p1;

    assign run = (state_q != IDLE);

    raster_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .H_W     (H_W),
        .V_W     (V_W)
    ) u_raster (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .hcnt         (hcnt),
        .vcnt         (vcnt),
        .end_of_frame (end_of_frame)
    );

    assign h_i    = 32'(hcnt);
    assign v_i    = 32'(vcnt);
    assign active = (h_i < HA_U) && (v_i < VA_U);
    assign hs_act = (h_i >= HS_START) && (h_i < HS_END);
    assign vs_act = (v_i >= VS_START) && (v_i < VS_END);

`ifdef HDMI_TEST_PATTERN_EN
    localparam int unsigned BAR_PIX = H_ACTIVE / 8;
    assign pat_on  = pattern_sel;
    assign bar_rgb = bar_colour(3'(h_i / BAR_PIX));
`else
    assign pat_on  = 1'b0;
    assign bar_rgb = '0;
`endif

    // The pattern generator owns the active area, so upstream is neither
    // pulled nor blamed for missing pixels while it is selected.
    assign pix_ready   = run && active && !pat_on;
    assign frame_start = pix_ready && (hcnt == '0) && (vcnt == '0);
    assign uf_set      = pix_ready && !pix_valid;

    // Select the pixel to present: bars, upstream word, or black.
    always_comb begin
        rgb_d = '0;
        if (run && active) begin
            if (pat_on) begin
                rgb_d = bar_rgb;
            end else if (pix_valid) begin
                rgb_d = rgb_t'(pix_data);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: DRAIN lets the current frame finish before idling.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (!enable) state_d = DRAIN;
            DRAIN: begin
                if (enable) begin
                    state_d = RUN;
                end else if (end_of_frame) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage p0 -> p1: register DE, syncs and RGB together so they stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            hsync_p1 <= ~SYNC_POL;
            vsync_p1 <= ~SYNC_POL;
            rgb_p1   <= '0;
        end else begin
            vld_p1   <= run && active;
            hsync_p1 <= (run && hs_act) ? SYNC_POL : ~SYNC_POL;
            vsync_p1 <= (run && vs_act) ? SYNC_POL : ~SYNC_POL;
            rgb_p1   <= rgb_d;
        end
    end

    // Sticky underflow flag; a new underflow beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow <= 1'b0;
        end else if (uf_set) begin
            underflow <= 1'b1;
        end else if (underflow_clr) begin
            underflow <= 1'b0;
        end
    end

    // Count frames completed while the raster is running.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (run && end_of_frame) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign de    = vld_p1;
    assign hsync = hsync_p1;
    assign vsync = vsync_p1;
    assign red   = rgb_p1.r;
    assign green = rgb_p1.g;
    assign blue  = rgb_p1.b;

endmodule
